cpu_line_adapter: RTL and testbench



---
 rtl/cpu_line_pkg.sv | 25 ++
 rtl/line_lane.sv | 50 +++++
 rtl/cpu_line_adapter.sv | 168 ++++++++++++++++
 tb/tb_cpu_line_adapter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_line_pkg.sv
// cpu_line_pkg: shared constants and types for the CPU-to-line adapter.
//   - RV32I funct3 size/sign codes for loads and stores
//   - adapter FSM state encoding
//   - line geometry (16-byte lines, 4-bit byte offset)
package cpu_line_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned OFFSET_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    MERGE,
    WR_REQ,
    RESP
  } state_t;

endpackage

// File: rtl/line_lane.sv
// line_lane: combinational lane logic for a 128-bit line.
//   i_line    : current line contents
//   i_offset  : byte offset of the access within the line
//   i_funct3  : RV32I size/sign code
//   i_wdata   : right-aligned store data
//   o_rdata   : selected lane, sign- or zero-extended (0 for an illegal code)
//   o_merged  : i_line with the addressed byte/half/word replaced by i_wdata
module line_lane
  import cpu_line_pkg::*;
(
  input  logic [LINE_BYTES*8-1:0] i_line,
  input  logic [OFFSET_W-1:0]     i_offset,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_wdata,
  output logic [31:0]             o_rdata,
  output logic [LINE_BYTES*8-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  // Offsets are forced to natural alignment; misaligned accesses are
  // rejected upstream before they reach the lane logic.
  always_comb begin
    w_byte  = i_line[{i_offset, 3'b000} +: 8];
    w_half  = i_line[{i_offset[3:1], 4'b0000} +: 16];
    w_word  = i_line[{i_offset[3:2], 5'b00000} +: 32];
    o_rdata = '0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'b0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'b0, w_half};
      F3_W:    o_rdata = w_word;
      default: o_rdata = '0;
    endcase
  end

  always_comb begin
    o_merged = i_line;
    case (i_funct3[1:0])
      2'd0:    o_merged[{i_offset, 3'b000} +: 8]         = i_wdata[7:0];
      2'd1:    o_merged[{i_offset[3:1], 4'b0000} +: 16]  = i_wdata[15:0];
      2'd2:    o_merged[{i_offset[3:2], 5'b00000} +: 32] = i_wdata;
      default: o_merged = i_line;
    endcase
  end

endmodule

// File: rtl/cpu_line_adapter.sv
// cpu_line_adapter: turns RV32I byte/half/word loads and stores into 128-bit
// line reads and writes, with a one-entry write-through line buffer.
//   iCLK, iRST                 : clock, synchronous active-high reset
//   cpu_addr/re/we/funct3/wdata: CPU request, held until cpu_ack
//   cpu_rdata/ack/err/stall    : CPU response
//   mem_addr/MemRead/MemWrite  : line request towards memory
//   mem_data_out/data_in       : line write / read data
//   mem_rvalid, mem_wait       : read data valid, downstream busy
module cpu_line_adapter
  import cpu_line_pkg::*;
#(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned XLEN   = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [XLEN-1:0]   cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [XLEN-1:0]   cpu_wdata,
  output logic [XLEN-1:0]   cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_rvalid,
  input  logic              mem_wait
);

  state_t r_state, w_state_d;

  logic              r_valid;
  logic [25:0]       r_tag;
  logic [DATA_W-1:0] r_buf;
  logic [29:0]       r_addr;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_wdata;
  logic              r_store;
  logic              r_ack;
  logic              r_err;
  logic [XLEN-1:0]   r_rdata;

  logic              w_req, w_hit, w_f3_ok, w_misalign, w_fault;
  logic              w_ack_d, w_err_d;
  logic [XLEN-1:0]   w_rdata_d, w_load_data;
  logic [DATA_W-1:0] w_merged;
  logic              w_unused_addr;

  // Address bits above the 26-bit line address carry no meaning here.
  assign w_unused_addr = ^cpu_addr[31:30];

  // While the ack is visible the CPU is still holding the old request;
  // blanking sampling for that cycle keeps it from being replayed.
  assign w_req = (cpu_re | cpu_we) & ~r_ack;
  assign w_hit = r_valid && (r_tag == cpu_addr[29:4]);

  always_comb begin
    if (cpu_we) begin
      w_f3_ok = (cpu_funct3 == F3_B) || (cpu_funct3 == F3_H) || (cpu_funct3 == F3_W);
    end else begin
      w_f3_ok = (cpu_funct3 == F3_B) || (cpu_funct3 == F3_H) || (cpu_funct3 == F3_W) ||
                (cpu_funct3 == F3_BU) || (cpu_funct3 == F3_HU);
    end
    w_misalign = ((cpu_funct3[1:0] == 2'd1) && cpu_addr[0]) ||
                 ((cpu_funct3[1:0] == 2'd2) && (cpu_addr[1:0] != 2'b00));
    w_fault    = !w_f3_ok || w_misalign || (cpu_addr[29:4] == 26'd0);
  end

  line_lane u_lane (
    .i_line   (r_buf),
    .i_offset (r_addr[3:0]),
    .i_funct3 (r_f3),
    .i_wdata  (r_wdata),
    .o_rdata  (w_load_data),
    .o_merged (w_merged)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= IDLE;
    else      r_state <= w_state_d;
  end

  always_comb begin
    w_state_d    = r_state;
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    w_ack_d      = 1'b0;
    w_err_d      = 1'b0;
    w_rdata_d    = '0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_fault) begin
            w_ack_d = 1'b1;
            w_err_d = 1'b1;
          end else if (w_hit) begin
            w_state_d = cpu_we ? MERGE : RESP;
          end else begin
            w_state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        mem_MemRead = 1'b1;
        if (!mem_wait) w_state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) w_state_d = r_store ? MERGE : RESP;
      end
      MERGE: w_state_d = WR_REQ;
      WR_REQ: begin
        mem_MemWrite = 1'b1;
        if (!mem_wait) w_state_d = RESP;
      end
      RESP: begin
        w_ack_d   = 1'b1;
        w_rdata_d = r_store ? '0 : w_load_data;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_f3    <= '0;
      r_wdata <= '0;
      r_store <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_ack_d;
      r_err   <= w_err_d;
      r_rdata <= w_rdata_d;
      if (r_state == IDLE && w_req) begin
        r_addr  <= cpu_addr[29:0];
        r_f3    <= cpu_funct3;
        r_wdata <= cpu_wdata;
        r_store <= cpu_we;
      end
      if (r_state == RD_WAIT && mem_rvalid) begin
        r_buf   <= mem_data_in;
        r_valid <= 1'b1;
        r_tag   <= r_addr[29:4];
      end
      if (r_state == MERGE) r_buf <= w_merged;
    end
  end

  assign cpu_ack      = r_ack;
  assign cpu_err      = r_err;
  assign cpu_rdata    = r_rdata;
  assign cpu_stall    = (cpu_re | cpu_we) & ~cpu_ack;
  assign mem_addr     = r_addr[29:4];
  assign mem_data_out = (r_state == WR_REQ) ? r_buf : '0;

endmodule

// File: tb/tb_cpu_line_adapter.sv
// Scoreboard bench for cpu_line_adapter: directed accesses push the expected
// ack payload into a queue; a monitor pops and compares on every cpu_ack.
// A small memory model answers line reads/writes with programmable waits.
module tb_cpu_line_adapter;
  import cpu_line_pkg::*;

  logic         clk = 1'b0;
  logic         iRST;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_re, cpu_we, cpu_ack, cpu_err, cpu_stall;
  logic [2:0]   cpu_funct3;
  logic [25:0]  mem_addr;
  logic         mem_MemRead, mem_MemWrite, mem_rvalid, mem_wait;
  logic [127:0] mem_data_out, mem_data_in;

  always #5 clk = ~clk;

  cpu_line_adapter dut (
    .iCLK(clk), .iRST(iRST),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_rvalid(mem_rvalid), .mem_wait(mem_wait)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  // Memory model
  logic [127:0] mem_lines [logic [25:0]];
  logic [127:0] last_wr = '0;
  logic [25:0]  rd_tag = '0, last_rd_tag = '0;
  int rd_lat = 2, rd_cnt = 0, rd_wait_left = 0, wr_wait_left = 0;
  int n_rd_cyc = 0, n_rd_acc = 0, n_wr_cyc = 0, n_wr_acc = 0;

  initial begin
    mem_rvalid  = 1'b0;
    mem_wait    = 1'b0;
    mem_data_in = '0;
  end

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        mem_rvalid  = 1'b1;
        mem_data_in = mem_lines.exists(rd_tag) ? mem_lines[rd_tag] : '0;
      end
    end
    mem_wait = 1'b0;
    if (mem_MemRead === 1'b1) begin
      n_rd_cyc++;
      if (rd_wait_left > 0) begin
        mem_wait = 1'b1;
        rd_wait_left--;
      end else begin
        rd_cnt      = rd_lat;
        rd_tag      = mem_addr;
        last_rd_tag = mem_addr;
        n_rd_acc++;
      end
    end
    if (mem_MemWrite === 1'b1) begin
      n_wr_cyc++;
      if (wr_wait_left > 0) begin
        mem_wait = 1'b1;
        wr_wait_left--;
      end else begin
        mem_lines[mem_addr] = mem_data_out;
        last_wr             = mem_data_out;
        n_wr_acc++;
      end
    end
  end

  // Ack monitor
  always @(negedge clk) begin
    if (cpu_ack === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_ack", 128'(cpu_ack), 128'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_rdata"}, 128'(cpu_rdata), 128'(e.rd));
        check({e.name, "_err"}, 128'(cpu_err), 128'(e.err));
      end
    end
  end

  task automatic access(input string name, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int lat;
    exp_t e;
    e.rd = exp_rd; e.err = exp_err; e.name = name;
    q.push_back(e);
    @(negedge clk);
    cpu_addr = addr; cpu_funct3 = f3; cpu_wdata = wd;
    cpu_we = st; cpu_re = !st;
    #1;
    check({name, "_stall"}, 128'(cpu_stall), 128'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (cpu_ack !== 1'b1 && lat < 60);
    check({name, "_lat"}, 128'(lat), 128'(exp_lat));
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  int rc0, ra0, wc0, wa0;

  initial begin
    mem_lines[26'h10] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    mem_lines[26'h20] = 128'h8765ABCD_22222222_33333333_444455F0;
    mem_lines[26'h30] = 128'h0;
    iRST = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 128'(cpu_ack), 0);
    check("rst_err", 128'(cpu_err), 0);
    check("rst_rdata", 128'(cpu_rdata), 0);
    check("rst_rd", 128'(mem_MemRead), 0);
    check("rst_wr", 128'(mem_MemWrite), 0);
    check("rst_dout", mem_data_out, 0);
    check("rst_stall", 128'(cpu_stall), 0);
    iRST = 1'b0;

    // Miss fill then hits on the same line
    ra0 = n_rd_acc;
    access("lw100_miss", 0, F3_W, 32'h100, 0, 32'hAAAAAAAA, 0, 5);
    check("lw100_reads", 128'(n_rd_acc - ra0), 1);
    check("lw100_tag", 128'(last_rd_tag), 128'h10);
    access("lw104_hit", 0, F3_W, 32'h104, 0, 32'hBBBBBBBB, 0, 2);
    access("lw10c_hit", 0, F3_W, 32'h10C, 0, 32'hDDDDDDDD, 0, 2);
    check("hits_no_read", 128'(n_rd_acc - ra0), 1);

    // Sign/zero extension and store merges on line 0x20
    access("lb200", 0, F3_B, 32'h200, 0, 32'hFFFFFFF0, 0, 5);
    access("lbu200", 0, F3_BU, 32'h200, 0, 32'h000000F0, 0, 2);
    ra0 = n_rd_acc; wa0 = n_wr_acc;
    access("sb201", 1, F3_B, 32'h201, 32'hABCDEF5A, 0, 0, 4);
    check("sb201_writes", 128'(n_wr_acc - wa0), 1);
    check("sb201_reads", 128'(n_rd_acc - ra0), 0);
    check("sb201_line", last_wr, 128'h8765ABCD_22222222_33333333_44445AF0);
    access("lh20e", 0, F3_H, 32'h20E, 0, 32'hFFFF8765, 0, 2);
    access("lhu20e", 0, F3_HU, 32'h20E, 0, 32'h00008765, 0, 2);
    access("sw208", 1, F3_W, 32'h208, 32'hCAFEF00D, 0, 0, 4);
    check("sw208_line", last_wr, 128'h8765ABCD_CAFEF00D_33333333_44445AF0);
    access("sh20c", 1, F3_H, 32'h20C, 32'h1234BEEF, 0, 0, 4);
    check("sh20c_line", last_wr, 128'h8765BEEF_CAFEF00D_33333333_44445AF0);
    access("lw208", 0, F3_W, 32'h208, 0, 32'hCAFEF00D, 0, 2);

    // Downstream back-pressure on a store miss
    rc0 = n_rd_cyc; ra0 = n_rd_acc; wc0 = n_wr_cyc; wa0 = n_wr_acc;
    rd_wait_left = 3; wr_wait_left = 2;
    access("sw304_wait", 1, F3_W, 32'h304, 32'h600DF00D, 0, 0, 12);
    check("wait_rd_cyc", 128'(n_rd_cyc - rc0), 4);
    check("wait_rd_acc", 128'(n_rd_acc - ra0), 1);
    check("wait_wr_cyc", 128'(n_wr_cyc - wc0), 3);
    check("wait_wr_acc", 128'(n_wr_acc - wa0), 1);
    check("wait_mem", mem_lines[26'h30], 128'h00000000_00000000_600DF00D_00000000);

    // Faults: 1-cycle ack with error and no memory traffic
    rc0 = n_rd_cyc; wc0 = n_wr_cyc;
    access("f_lh101", 0, F3_H, 32'h101, 0, 0, 1, 1);
    access("f_lw102", 0, F3_W, 32'h102, 0, 0, 1, 1);
    access("f_lw00c", 0, F3_W, 32'h00C, 0, 0, 1, 1);
    access("f_f3_3", 0, 3'd3, 32'h100, 0, 0, 1, 1);
    access("f_sbu", 1, F3_BU, 32'h300, 32'h11, 0, 1, 1);
    check("fault_no_rd", 128'(n_rd_cyc - rc0), 0);
    check("fault_no_wr", 128'(n_wr_cyc - wc0), 0);

    // Reset while waiting for read data; the late rvalid lands in IDLE
    rd_lat = 6;
    @(negedge clk);
    cpu_addr = 32'h100; cpu_funct3 = F3_W; cpu_re = 1'b1;
    repeat (2) @(negedge clk);
    iRST = 1'b1; cpu_re = 1'b0;
    repeat (2) @(negedge clk);
    iRST = 1'b0;
    check("rstmid_rd", 128'(mem_MemRead), 0);
    repeat (6) @(negedge clk) check("rstmid_no_ack", 128'(cpu_ack), 0);
    rd_lat = 2;
    ra0 = n_rd_acc;
    access("lw304_after_rst", 0, F3_W, 32'h304, 0, 32'h600DF00D, 0, 5);
    access("lw100_after_rst", 0, F3_W, 32'h100, 0, 32'hAAAAAAAA, 0, 5);
    check("after_rst_reads", 128'(n_rd_acc - ra0), 2);

    repeat (3) @(negedge clk);
    check("acks_outstanding", 128'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
